// File: rtl/zebra_pattern_generator.sv
// rtl/zebra_pattern_generator.sv - Raster pixel source with a programmable band of white/black stripes on gray
module zebra_pattern_generator #(
    parameter int           IMG_WIDTH   = 320,
    parameter int           IMG_HEIGHT  = 240,
    parameter int           W           = 8,
    parameter logic [W-1:0] WHITE_LEVEL = 8'd230,
    parameter logic [W-1:0] BLACK_LEVEL = 8'd20,
    parameter logic [W-1:0] GRAY_LEVEL  = 8'd128,
    parameter int           HW          = $clog2(IMG_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [HW-1:0] cfg_start_row,
    input  logic [HW-1:0] cfg_stripe_height,
    input  logic [HW-1:0] cfg_num_stripes,
    input  logic          cfg_continuous,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [W-1:0]  y_data,
    output logic          y_sof,
    output logic          y_eol,
    output logic          busy,
    output logic          frame_done
);
    localparam int            XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [HW-1:0] Y_LAST = HW'(IMG_HEIGHT - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state, state_next;

    logic [XW-1:0] x;
    logic [HW-1:0] y;
    logic [HW-1:0] srow;
    logic [HW-1:0] k;
    logic [HW-1:0] lat_start;
    logic [HW-1:0] lat_h;
    logic [HW-1:0] lat_num;

    logic          fire;
    logic          row_end;
    logic          last_pix;
    logic          in_band;
    logic          load;
    logic [HW-1:0] cfg_h_eff;
    logic [XW-1:0] step_x;
    logic [HW-1:0] step_y;
    logic [HW-1:0] step_srow;
    logic [HW-1:0] step_k;

    // A row is striped while it is at/after the band start and the stripe index has not run out.
    function automatic logic [W-1:0] row_value(input logic [HW-1:0] row,
                                               input logic [HW-1:0] idx,
                                               input logic [HW-1:0] first,
                                               input logic [HW-1:0] count);
        if ((row >= first) && (idx < count))
            return idx[0] ? BLACK_LEVEL : WHITE_LEVEL;
        return GRAY_LEVEL;
    endfunction

    assign y_valid = (state == S_RUN);
    assign busy    = (state == S_RUN);

    always_comb begin
        fire      = (state == S_RUN) && y_ready;
        row_end   = (x == X_LAST);
        last_pix  = row_end && (y == Y_LAST);
        in_band   = (y >= lat_start) && (k < lat_num);
        load      = ((state == S_IDLE) && start) || (fire && last_pix && cfg_continuous);
        cfg_h_eff = (cfg_stripe_height == '0) ? HW'(1) : cfg_stripe_height;
        step_x    = row_end ? '0 : x + 1'b1;
        step_y    = row_end ? y + 1'b1 : y;
        step_srow = srow;
        step_k    = k;
        if (row_end && in_band) begin
            if (srow == lat_h - 1'b1) begin
                step_srow = '0;
                step_k    = k + 1'b1;
            end else begin
                step_srow = srow + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (fire && last_pix && !cfg_continuous) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The pixel register always holds the beat being presented; it only moves on a handshake or a (re)latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            srow       <= '0;
            k          <= '0;
            lat_start  <= '0;
            lat_h      <= '0;
            lat_num    <= '0;
            y_data     <= '0;
            y_sof      <= 1'b0;
            y_eol      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fire && last_pix;
            if (load) begin
                x         <= '0;
                y         <= '0;
                srow      <= '0;
                k         <= '0;
                lat_start <= cfg_start_row;
                lat_h     <= cfg_h_eff;
                lat_num   <= cfg_num_stripes;
                y_data    <= row_value('0, '0, cfg_start_row, cfg_num_stripes);
                y_sof     <= 1'b1;
                y_eol     <= (X_LAST == '0);
            end else if (fire) begin
                if (last_pix) begin
                    y_sof <= 1'b0;
                    y_eol <= 1'b0;
                end else begin
                    x      <= step_x;
                    y      <= step_y;
                    srow   <= step_srow;
                    k      <= step_k;
                    y_data <= row_value(step_y, step_k, lat_start, lat_num);
                    y_sof  <= 1'b0;
                    y_eol  <= (step_x == X_LAST);
                end
            end
        end
    end
endmodule

// File: tb/tb_zebra_pattern_generator.sv
// tb/tb_zebra_pattern_generator.sv - Randomized self-checking bench for zebra_pattern_generator
module tb_zebra_pattern_generator;
    localparam int IW  = 8;
    localparam int IH  = 12;
    localparam int DW  = 8;
    localparam int HWB = $clog2(IH + 1);
    localparam logic [DW-1:0] WHITE = 8'd230;
    localparam logic [DW-1:0] BLACK = 8'd20;
    localparam logic [DW-1:0] GRAY  = 8'd128;

    logic           clk;
    logic           rst;
    logic           start;
    logic [HWB-1:0] cfg_start_row;
    logic [HWB-1:0] cfg_stripe_height;
    logic [HWB-1:0] cfg_num_stripes;
    logic           cfg_continuous;
    logic           y_valid;
    logic           y_ready;
    logic [DW-1:0]  y_data;
    logic           y_sof;
    logic           y_eol;
    logic           busy;
    logic           frame_done;

    zebra_pattern_generator #(
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .W          (DW),
        .WHITE_LEVEL(WHITE),
        .BLACK_LEVEL(BLACK),
        .GRAY_LEVEL (GRAY),
        .HW         (HWB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_start_row    (cfg_start_row),
        .cfg_stripe_height(cfg_stripe_height),
        .cfg_num_stripes  (cfg_num_stripes),
        .cfg_continuous   (cfg_continuous),
        .y_valid          (y_valid),
        .y_ready          (y_ready),
        .y_data           (y_data),
        .y_sof            (y_sof),
        .y_eol            (y_eol),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame config, next expected beat position, per-frame tallies.
    int          m_active = 0;
    int          m_start  = 0;
    int          m_h      = 0;
    int          m_num    = 0;
    int          ex       = 0;
    int          ey       = 0;
    int          frames   = 0;
    int          f_hs     = 0;
    int          f_eol    = 0;
    int          f_sof    = 0;
    bit          exp_done = 1'b0;
    bit          stalled  = 1'b0;
    logic [DW-1:0] s_data;
    logic        s_sof;
    logic        s_eol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (row %0d col %0d)", tag, got, expv, ey, ex);
        end
    endtask

    function automatic logic [DW-1:0] exp_pix(input int r);
        int h;
        h = (m_h == 0) ? 1 : m_h;
        if (r >= m_start && r < m_start + m_num * h)
            return (((r - m_start) / h) % 2 == 1) ? BLACK : WHITE;
        return GRAY;
    endfunction

    task automatic latch_cfg();
        m_start = int'(cfg_start_row);
        m_h     = int'(cfg_stripe_height);
        m_num   = int'(cfg_num_stripes);
        ex      = 0;
        ey      = 0;
    endtask

    // Drive one cycle at a negedge, score the beat that the coming posedge consumes, then check outputs after it.
    task automatic tick(input bit rdy, input bit st);
        bit last;
        y_ready  = rdy;
        start    = st;
        exp_done = 1'b0;
        stalled  = 1'b0;
        if (m_active != 0 && rdy) begin
            check("data", 32'(y_data), 32'(exp_pix(ey)));
            check("sof", 32'(y_sof), 32'(ex == 0 && ey == 0));
            check("eol", 32'(y_eol), 32'(ex == IW - 1));
            f_hs++;
            f_eol += int'(y_eol);
            f_sof += int'(y_sof);
            last = (ex == IW - 1) && (ey == IH - 1);
            if (ex == IW - 1) begin
                ex = 0;
                ey++;
            end else begin
                ex++;
            end
            if (last) begin
                check("hs_count", 32'(f_hs), 32'(IW * IH));
                check("eol_count", 32'(f_eol), 32'(IH));
                check("sof_count", 32'(f_sof), 32'd1);
                f_hs = 0;
                f_eol = 0;
                f_sof = 0;
                frames++;
                exp_done = 1'b1;
                if (cfg_continuous)
                    latch_cfg();
                else
                    m_active = 0;
            end
        end else if (m_active != 0) begin
            stalled = 1'b1;
            s_data  = y_data;
            s_sof   = y_sof;
            s_eol   = y_eol;
        end else if (st) begin
            latch_cfg();
            m_active = 1;
        end
        @(negedge clk);
        check("valid", 32'(y_valid), 32'(m_active));
        check("busy", 32'(busy), 32'(m_active));
        check("frame_done", 32'(frame_done), 32'(exp_done));
        if (stalled) begin
            check("stall_data", 32'(y_data), 32'(s_data));
            check("stall_sof", 32'(y_sof), 32'(s_sof));
            check("stall_eol", 32'(y_eol), 32'(s_eol));
        end
    endtask

    task automatic run_frame(input int s, input int h, input int n, input bit bp, input int pulse_at);
        int f0;
        bit r;
        cfg_start_row     = HWB'(s);
        cfg_stripe_height = HWB'(h);
        cfg_num_stripes   = HWB'(n);
        cfg_continuous    = 1'b0;
        tick(1'b1, 1'b1);
        f0 = frames;
        for (int i = 0; i < 4000 && frames == f0; i++) begin
            if (i == 20) begin
                cfg_start_row     = HWB'($urandom_range(0, 15));
                cfg_stripe_height = HWB'($urandom_range(0, 15));
                cfg_num_stripes   = HWB'($urandom_range(0, 15));
            end
            r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick(r, i == pulse_at);
        end
        check("frame_end", 32'(frames - f0), 32'd1);
    endtask

    task automatic run_continuous();
        int f0;
        cfg_start_row     = HWB'(3);
        cfg_stripe_height = HWB'(2);
        cfg_num_stripes   = HWB'(3);
        cfg_continuous    = 1'b1;
        tick(1'b1, 1'b1);
        f0 = frames;
        for (int i = 0; i < 4000 && frames < f0 + 2; i++) begin
            if (frames == f0 && ey == 6)
                cfg_num_stripes = HWB'(1);
            if (frames == f0 + 1)
                cfg_continuous = 1'b0;
            tick(1'b1, 1'b0);
        end
        check("cont_frames", 32'(frames - f0), 32'd2);
        tick(1'b1, 1'b0);
    endtask

    task automatic reset_mid_frame();
        cfg_start_row     = HWB'(2);
        cfg_stripe_height = HWB'(3);
        cfg_num_stripes   = HWB'(2);
        cfg_continuous    = 1'b0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 500 && !(ex == 3 && ey == 5); i++)
            tick(1'b1, 1'b0);
        check("rst_point", 32'(ey * 100 + ex), 32'd503);
        rst     = 1'b1;
        y_ready = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(y_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(frame_done), 32'd0);
        rst      = 1'b0;
        m_active = 0;
        stalled  = 1'b0;
        exp_done = 1'b0;
        f_hs     = 0;
        f_eol    = 0;
        f_sof    = 0;
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        y_ready           = 1'b0;
        cfg_start_row     = '0;
        cfg_stripe_height = '0;
        cfg_num_stripes   = '0;
        cfg_continuous    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_data", 32'(y_data), 32'd0);
        check("rst_sof", 32'(y_sof), 32'd0);
        check("rst_eol", 32'(y_eol), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);

        run_frame(3, 2, 3, 1'b0, -1);
        run_frame(3, 2, 3, 1'b1, -1);
        run_continuous();
        run_frame(10, 4, 6, 1'b1, -1);
        run_frame(0, 0, 3, 1'b0, -1);
        run_frame(5, 2, 0, 1'b1, -1);
        run_frame(13, 1, 3, 1'b0, -1);
        run_frame(4, 3, 2, 1'b1, 40);
        reset_mid_frame();
        run_frame(2, 1, 4, 1'b0, -1);
        for (int i = 0; i < 8; i++)
            run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 8)), 1'b1, int'($urandom_range(0, 90)));
        tick(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
